// File: rtl/clk_freq_mon.sv
// Reference-clock frequency monitor: counts meas_clk edges over a gate window of clk.
// Define CLK_FREQ_MON_IRQ_EN to add the sticky irq output and its irq_clr input.
module clk_freq_mon #(
    parameter int GATE_CYCLES  = 24000,
    parameter int CNT_W        = 16,
    parameter int EXP_COUNT    = 1000,
    parameter int TOL          = 2,
    parameter int GOOD_WINDOWS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             meas_clk,
    input  logic             enable,
`ifdef CLK_FREQ_MON_IRQ_EN
    input  logic             irq_clr,
    output logic             irq,
`endif
    output logic [CNT_W-1:0] count,
    output logic             count_valid,
    output logic             in_range,
    output logic             clk_ok,
    output logic             clk_lost
);

    localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int GOOD_W = $clog2(GOOD_WINDOWS + 1);
    localparam int CMP_W  = CNT_W + 1;
    localparam int LO_LIM = (EXP_COUNT > TOL) ? EXP_COUNT - TOL : 0;
    localparam int HI_LIM = EXP_COUNT + TOL;

    typedef enum logic [1:0] {IDLE, ARM, GATE, CALC} state_t;

    function automatic logic [CNT_W-1:0] bin2gray(input logic [CNT_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [CNT_W-1:0] gray2bin(input logic [CNT_W-1:0] g);
        logic [CNT_W-1:0] b;
        b[CNT_W-1] = g[CNT_W-1];
        for (int i = CNT_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic within_tol(input logic [CNT_W-1:0] d);
        logic [CMP_W-1:0] dx;
        dx = {1'b0, d};
        return (dx >= CMP_W'(LO_LIM)) && (dx <= CMP_W'(HI_LIM));
    endfunction

    logic [CNT_W-1:0]  meas_cnt;
    logic [CNT_W-1:0]  meas_cnt_nxt;
    logic [CNT_W-1:0]  meas_gray;
    logic [CNT_W-1:0]  gray_p0;
    logic [CNT_W-1:0]  gray_p1;
    logic [CNT_W-1:0]  snap;
    logic [CNT_W-1:0]  start_cnt;
    logic [CNT_W-1:0]  end_cnt;
    logic [CNT_W-1:0]  delta;
    logic [GATE_W-1:0] gate_cnt;
    logic [GOOD_W-1:0] good_cnt;
    logic [GOOD_W-1:0] good_inc;
    logic              gate_last;
    logic              calc_en;
    logic              abort;
    logic              delta_ok;
    state_t            state;
    state_t            state_nxt;

    // meas_clk domain: free-running counter, Gray-coded in a register before crossing
    assign meas_cnt_nxt = meas_cnt + CNT_W'(1);

    always_ff @(posedge meas_clk or posedge rst) begin
        if (rst) begin
            meas_cnt  <= '0;
            meas_gray <= '0;
        end else begin
            meas_cnt  <= meas_cnt_nxt;
            meas_gray <= bin2gray(meas_cnt_nxt);
        end
    end

    // clk domain: two-flop synchroniser on the Gray value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gray_p0 <= '0;
            gray_p1 <= '0;
        end else begin
            gray_p0 <= meas_gray;
            gray_p1 <= gray_p0;
        end
    end

    assign snap      = gray2bin(gray_p1);
    assign delta     = snap - start_cnt;
    assign delta_ok  = within_tol(delta);
    assign gate_last = (gate_cnt == GATE_W'(GATE_CYCLES - 1));
    assign calc_en   = (state == GATE) && enable && gate_last;
    assign abort     = (state != IDLE) && !enable;
    assign good_inc  = (good_cnt == GOOD_W'(GOOD_WINDOWS)) ? good_cnt : good_cnt + GOOD_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = ARM;
            ARM:     state_nxt = enable ? GATE : IDLE;
            GATE:    if (!enable) state_nxt = IDLE;
                     else if (gate_last) state_nxt = CALC;
            CALC:    state_nxt = enable ? GATE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Results are registered on entry to CALC so they are visible alongside count_valid.
    always_comb begin
        count_valid = (state == CALC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_cnt  <= '0;
            start_cnt <= '0;
            end_cnt   <= '0;
            count     <= '0;
            in_range  <= 1'b0;
            clk_lost  <= 1'b0;
            good_cnt  <= '0;
            clk_ok    <= 1'b0;
        end else begin
            gate_cnt <= (state == GATE && !gate_last) ? gate_cnt + GATE_W'(1) : '0;
            if (state == ARM)  start_cnt <= snap;
            if (state == CALC) start_cnt <= end_cnt;
            if (calc_en) begin
                end_cnt  <= snap;
                count    <= delta;
                in_range <= delta_ok;
                clk_lost <= (delta == '0);
                if (delta_ok) begin
                    good_cnt <= good_inc;
                    clk_ok   <= (good_inc == GOOD_W'(GOOD_WINDOWS));
                end else begin
                    good_cnt <= '0;
                    clk_ok   <= 1'b0;
                end
            end else if (abort) begin
                good_cnt <= '0;
                clk_ok   <= 1'b0;
            end
        end
    end

`ifdef CLK_FREQ_MON_IRQ_EN
    logic clk_ok_q;
    logic irq_set;

    assign irq_set = (clk_ok_q && !clk_ok) || ((state == CALC) && clk_lost);

    // Set has priority over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_ok_q <= 1'b0;
            irq      <= 1'b0;
        end else begin
            clk_ok_q <= clk_ok;
            if (irq_set)      irq <= 1'b1;
            else if (irq_clr) irq <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_clk_freq_mon.sv
// Directed bench for clk_freq_mon, scaled to a 240-cycle gate so a window is 10 meas edges.
module tb_clk_freq_mon;

    localparam int GATE = 240;
    localparam int CW   = 5;
    localparam int HALF_1M  = 480;
    localparam int HALF_1M5 = 320;

    logic          clk;
    logic          rst;
    logic          meas_clk;
    logic          enable;
    logic [CW-1:0] count;
    logic          count_valid;
    logic          in_range;
    logic          clk_ok;
    logic          clk_lost;
`ifdef CLK_FREQ_MON_IRQ_EN
    logic          irq;
    logic          irq_clr;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int meas_half = HALF_1M;
    bit meas_run  = 1'b1;

    clk_freq_mon #(
        .GATE_CYCLES (GATE),
        .CNT_W       (CW),
        .EXP_COUNT   (10),
        .TOL         (2),
        .GOOD_WINDOWS(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .meas_clk   (meas_clk),
        .enable     (enable),
`ifdef CLK_FREQ_MON_IRQ_EN
        .irq_clr    (irq_clr),
        .irq        (irq),
`endif
        .count      (count),
        .count_valid(count_valid),
        .in_range   (in_range),
        .clk_ok     (clk_ok),
        .clk_lost   (clk_lost)
    );

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    initial begin
        meas_clk = 1'b0;
        #7;
        forever begin
            #(meas_half);
            if (meas_run) meas_clk = ~meas_clk;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!count_valid && cyc < 1000);
        if (!count_valid) check("valid_timeout", 0, 1);
    endtask

    task automatic window(input string tag, input int lo, input int hi,
                          input int exp_in, input int exp_ok, input int exp_lat);
        int cyc;
        wait_valid(cyc);
        if (exp_lat > 0) check({tag, "_latency"}, cyc, exp_lat);
        check($sformatf("%s_count%0d_in_%0d_%0d", tag, count, lo, hi),
              int'(count >= lo && count <= hi), 1);
        check({tag, "_in_range"}, int'(in_range), exp_in);
        check({tag, "_clk_ok"}, int'(clk_ok), exp_ok);
    endtask

    task automatic restart(input int half);
        enable = 1'b0;
        repeat (4) @(negedge clk);
        meas_half = half;
        meas_run  = 1'b1;
        enable    = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_count"}, int'(count), 0);
        check({tag, "_count_valid"}, int'(count_valid), 0);
        check({tag, "_in_range"}, int'(in_range), 0);
        check({tag, "_clk_ok"}, int'(clk_ok), 0);
        check({tag, "_clk_lost"}, int'(clk_lost), 0);
    endtask

    initial begin
        int saw;
        rst    = 1'b1;
        enable = 1'b0;
`ifdef CLK_FREQ_MON_IRQ_EN
        irq_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_zero("reset");
`ifdef CLK_FREQ_MON_IRQ_EN
        check("reset_irq", int'(irq), 0);
`endif
        rst    = 1'b0;
        enable = 1'b1;

        // Nominal: clk_ok rises with the 4th in-range window
        window("nom1", 9, 11, 1, 0, GATE + 2);
        @(negedge clk);
        check("nom_valid_pulse", int'(count_valid), 0);
        window("nom2", 9, 11, 1, 0, GATE);
        check("nom2_clk_lost", int'(clk_lost), 0);
        window("nom3", 9, 11, 1, 0, GATE + 1);
        window("nom4", 9, 11, 1, 1, GATE + 1);
        window("nom5", 9, 11, 1, 1, GATE + 1);

        // Wrong frequency, then back to nominal
        restart(HALF_1M5);
        window("fast1", 14, 16, 0, 0, GATE + 2);
        window("fast2", 14, 16, 0, 0, GATE + 1);
        window("fast3", 14, 16, 0, 0, GATE + 1);
        restart(HALF_1M);
        window("back1", 9, 11, 1, 0, GATE + 2);
        window("back2", 9, 11, 1, 0, GATE + 1);
        window("back3", 9, 11, 1, 0, GATE + 1);
        window("back4", 9, 11, 1, 1, GATE + 1);

        // Loss of meas_clk while clk_ok is high
        meas_run = 1'b0;
        window("loss1", 0, 1, 0, 0, GATE + 1);
        window("loss2", 0, 0, 0, 0, GATE + 1);
        check("loss2_clk_lost", int'(clk_lost), 1);
`ifdef CLK_FREQ_MON_IRQ_EN
        check("loss_irq_set", int'(irq), 1);
        repeat (2) @(negedge clk);
        check("loss_irq_sticky", int'(irq), 1);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        check("loss_irq_clr", int'(irq), 0);
`endif

        // Abort mid-window: results hold, clk_ok drops, no count_valid
        restart(HALF_1M);
        window("pre_abort1", 9, 11, 1, 0, GATE + 2);
        window("pre_abort2", 9, 11, 1, 0, GATE + 1);
        window("pre_abort3", 9, 11, 1, 0, GATE + 1);
        window("pre_abort4", 9, 11, 1, 1, GATE + 1);
        repeat (100) @(negedge clk);
        enable = 1'b0;
        saw = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (count_valid) saw = 1;
        end
        check("abort_no_valid", saw, 0);
        check("abort_clk_ok", int'(clk_ok), 0);
        check($sformatf("abort_count%0d_held", count), int'(count >= 9 && count <= 11), 1);
        check("abort_in_range_held", int'(in_range), 1);
        enable = 1'b1;
        window("reenable", 9, 11, 1, 0, GATE + 2);

        // Reset pulsed mid-window with enable held
        repeat (50) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_zero("post_rst");
        window("after_rst", 9, 11, 1, 0, GATE + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
